// File: rtl/ft600_bus_arbiter.sv
// ft600_bus_arbiter: schedules the half-duplex FT600 245-sync bus between RX and TX bursts
module ft600_bus_arbiter #(
  parameter int MAX_BURST   = 64,
  parameter int TURN_CYCLES = 2,
  parameter int CNT_W       = 7
) (
  input  logic             ftdi_clk,
  input  logic             rst,
  input  logic             ftdi_rxf_n,
  input  logic             ftdi_txe_n,
  output logic             ftdi_oe_n,
  output logic             ftdi_rd_n,
  output logic             ftdi_wr_n,
  output logic             bus_drive_en,
  input  logic             rx_fifo_afull,
  output logic             rx_fifo_w_en,
  input  logic             tx_fifo_empty,
  output logic             tx_fifo_r_en,
  output logic             rx_active,
  output logic             tx_active,
  output logic [CNT_W-1:0] burst_words
);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RX_OE, RX_BURST, TX_DRIVE, TX_BURST, TURN} state_t;
  state_t state, nxt;
  logic rx_req, tx_req, at_max, last_tx;
  logic oe_n_q, rd_n_q, wr_n_q, bde_q;
  logic [TW-1:0] turn_cnt;
  logic [CNT_W-1:0] bw;
  assign rx_req       = !ftdi_rxf_n & !rx_fifo_afull;
  assign tx_req       = !ftdi_txe_n & !tx_fifo_empty;
  assign ftdi_oe_n    = oe_n_q;
  assign ftdi_rd_n    = rd_n_q;
  assign ftdi_wr_n    = wr_n_q | tx_fifo_empty;
  assign bus_drive_en = bde_q;
  assign rx_fifo_w_en = !rd_n_q & !ftdi_rxf_n;
  assign tx_fifo_r_en = !ftdi_wr_n & !ftdi_txe_n;
  assign rx_active    = state == RX_OE || state == RX_BURST;
  assign tx_active    = state == TX_DRIVE || state == TX_BURST;
  assign burst_words  = bw;
  assign at_max       = bw >= CNT_W'(MAX_BURST - 1);
  // next state: tie in IDLE goes opposite to the last served direction; bursts cut only for a waiting peer
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = (rx_req && (!tx_req || last_tx)) ? RX_OE : tx_req ? TX_DRIVE : IDLE;
      RX_OE:    nxt = RX_BURST;
      RX_BURST: nxt = (ftdi_rxf_n || rx_fifo_afull || (tx_req && rx_fifo_w_en && at_max)) ? TURN : RX_BURST;
      TX_DRIVE: nxt = TX_BURST;
      TX_BURST: nxt = (ftdi_txe_n || tx_fifo_empty || (rx_req && tx_fifo_r_en && at_max)) ? TURN : TX_BURST;
      TURN:     nxt = (turn_cnt == TW'(TURN_CYCLES - 1)) ? IDLE : TURN;
      default:  nxt = IDLE;
    endcase
  end
  // state and strobes registered from the next state so pins change cleanly on the edge
  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      oe_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      bde_q   <= 1'b0;
      last_tx <= 1'b1;
    end else begin
      state   <= nxt;
      oe_n_q  <= !(nxt == RX_OE || nxt == RX_BURST);
      rd_n_q  <= nxt != RX_BURST;
      wr_n_q  <= nxt != TX_BURST;
      bde_q   <= nxt == TX_DRIVE || nxt == TX_BURST;
      last_tx <= (state == RX_BURST && nxt == TURN) ? 1'b0 : (state == TX_BURST && nxt == TURN) ? 1'b1 : last_tx;
    end
  end
  // turnaround timer and saturating per-burst word counter
  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      turn_cnt <= '0;
      bw       <= '0;
    end else begin
      turn_cnt <= (state == TURN) ? turn_cnt + 1'b1 : '0;
      bw       <= (state == RX_OE || state == TX_DRIVE) ? '0 : ((rx_fifo_w_en || tx_fifo_r_en) && bw != '1) ? bw + 1'b1 : bw;
    end
  end
endmodule

// File: tb/tb_ft600_bus_arbiter.sv
// tb_ft600_bus_arbiter: vector table plus host/FIFO model sequences for the FT600 arbiter
module tb_ft600_bus_arbiter;
  logic ftdi_clk = 1'b0, rst = 1'b1;
  logic ftdi_rxf_n = 1'b1, ftdi_txe_n = 1'b1, rx_fifo_afull = 1'b0, tx_fifo_empty = 1'b1;
  logic ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, bus_drive_en, rx_fifo_w_en, tx_fifo_r_en, rx_active, tx_active;
  logic [6:0] burst_words;
  always #5 ftdi_clk = ~ftdi_clk;
  ft600_bus_arbiter #(.MAX_BURST(4), .TURN_CYCLES(2), .CNT_W(7)) dut (
    .ftdi_clk(ftdi_clk), .rst(rst), .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_oe_n(ftdi_oe_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n), .bus_drive_en(bus_drive_en),
    .rx_fifo_afull(rx_fifo_afull), .rx_fifo_w_en(rx_fifo_w_en), .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_r_en(tx_fifo_r_en), .rx_active(rx_active), .tx_active(tx_active), .burst_words(burst_words));
  typedef struct packed {
    logic [3:0] stim;
    logic [7:0] exp_o;
    logic [6:0] exp_bw;
  } vec_t;
  vec_t vecs[15];
  int n_cmp = 0, n_bad = 0;
  int host_rx, txq, rx_got, tx_sent, wr_low, t0;
  bit afull_f, txe_f;
  int bl_dir[16], bl_len[16], bl_gap[16];
  int nb, cur_dir, gap;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic clear_log();
    nb = 0; cur_dir = 0; gap = 0;
    for (int i = 0; i < 16; i++) begin bl_dir[i] = 0; bl_len[i] = 0; bl_gap[i] = 0; end
  endtask
  task automatic tick();
    int d;
    @(negedge ftdi_clk);
    ftdi_rxf_n = host_rx == 0;
    rx_fifo_afull = afull_f;
    ftdi_txe_n = txe_f;
    tx_fifo_empty = txq == 0;
    #1;
    chk("exclusion", {bus_drive_en & !ftdi_oe_n, rx_fifo_w_en & tx_fifo_r_en, tx_fifo_r_en & (txq == 0)}, 0);
    if (rx_fifo_w_en) begin host_rx--; rx_got++; end
    if (tx_fifo_r_en) begin txq--; tx_sent++; end
    if (!ftdi_wr_n) wr_low++;
    d = rx_fifo_w_en ? 1 : tx_fifo_r_en ? 2 : 0;
    if (d == 0) gap++;
    else begin
      if (d != cur_dir || gap != 0) begin
        if (nb < 16) begin bl_dir[nb] = d; bl_len[nb] = 0; bl_gap[nb] = gap; end
        nb++;
      end
      if (nb <= 16) bl_len[nb-1]++;
      cur_dir = d;
      gap = 0;
    end
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic until_cnt(input bit tx, input int target);
    for (int i = 0; i < 60 && (tx ? tx_sent : rx_got) < target; i++) tick();
    chk(tx ? "reach tx count" : "reach rx count", tx ? tx_sent : rx_got, target);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
    rx_got = 0; tx_sent = 0; wr_low = 0;
  endtask
  initial begin
    // stim = {rxf_n, txe_n, afull, empty}; exp_o = {oe_n, rd_n, wr_n, bde, w_en, r_en, rx_active, tx_active}
    vecs[0]  = '{4'b1101, 8'b11100000, 7'd0};
    vecs[1]  = '{4'b0101, 8'b11100000, 7'd0};
    vecs[2]  = '{4'b0101, 8'b01100010, 7'd0};
    vecs[3]  = '{4'b0101, 8'b00101010, 7'd0};
    vecs[4]  = '{4'b0101, 8'b00101010, 7'd1};
    vecs[5]  = '{4'b0101, 8'b00101010, 7'd2};
    vecs[6]  = '{4'b1101, 8'b00100010, 7'd3};
    vecs[7]  = '{4'b1101, 8'b11100000, 7'd3};
    vecs[8]  = '{4'b1000, 8'b11100000, 7'd3};
    vecs[9]  = '{4'b1000, 8'b11100000, 7'd3};
    vecs[10] = '{4'b1000, 8'b11110001, 7'd3};
    vecs[11] = '{4'b1000, 8'b11010101, 7'd0};
    vecs[12] = '{4'b1000, 8'b11010101, 7'd1};
    vecs[13] = '{4'b1001, 8'b11110001, 7'd2};
    vecs[14] = '{4'b1001, 8'b11100000, 7'd2};
    host_rx = 0; txq = 0; afull_f = 0; txe_f = 1;
    clear_log();
    tick();
    chk("reset outputs", {ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, bus_drive_en, rx_fifo_w_en, tx_fifo_r_en, rx_active, tx_active}, 8'b11100000);
    chk("reset burst_words", burst_words, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge ftdi_clk);
      {ftdi_rxf_n, ftdi_txe_n, rx_fifo_afull, tx_fifo_empty} = vecs[i].stim;
      #1;
      chk($sformatf("vec%0d outputs", i), {ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, bus_drive_en, rx_fifo_w_en, tx_fifo_r_en, rx_active, tx_active}, vecs[i].exp_o);
      chk($sformatf("vec%0d burst_words", i), burst_words, vecs[i].exp_bw);
    end
    // 8-word RX burst
    host_rx = 8; txq = 0; txe_f = 0;
    do_reset();
    run(30);
    chk("rx8 bursts", nb, 1);
    chk("rx8 dir", bl_dir[0], 1);
    chk("rx8 len", bl_len[0], 8);
    chk("rx8 burst_words", burst_words, 8);
    // 8-word TX burst
    host_rx = 0; txq = 8;
    do_reset();
    run(30);
    chk("tx8 bursts", nb, 1);
    chk("tx8 dir", bl_dir[0], 2);
    chk("tx8 len", bl_len[0], 8);
    chk("tx8 wr_n low cycles", wr_low, 8);
    chk("tx8 burst_words", burst_words, 8);
    // both pending from reset: RX first, then alternating 4-word bursts
    host_rx = 8; txq = 8;
    do_reset();
    run(50);
    chk("alt bursts", nb, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("alt dir%0d", k), bl_dir[k], (k % 2) ? 2 : 1);
      chk($sformatf("alt len%0d", k), bl_len[k], 4);
      if (k > 0) chk($sformatf("alt gap%0d", k), bl_gap[k], 4);
    end
    // afull mid-RX burst
    host_rx = 10; txq = 0;
    do_reset();
    until_cnt(0, 3);
    afull_f = 1;
    t0 = rx_got;
    tick();
    tick();
    chk("afull rd_n high", ftdi_rd_n, 1);
    run(4);
    chk("afull extra writes <=1", (rx_got - t0) <= 1, 1);
    afull_f = 0;
    run(30);
    chk("afull total rx", rx_got, 10);
    chk("afull bursts", nb, 2);
    // txe_n pulse mid-TX burst
    host_rx = 0; txq = 10;
    do_reset();
    until_cnt(1, 3);
    txe_f = 1;
    t0 = tx_sent;
    run(3);
    chk("txe high no r_en", tx_sent, t0);
    txe_f = 0;
    run(30);
    chk("txe total tx", tx_sent, 10);
    chk("txe fifo drained", txq, 0);
    chk("txe bursts", nb, 2);
    // async reset mid-RX burst, then a tie must go to RX
    host_rx = 10; txq = 0;
    do_reset();
    until_cnt(0, 3);
    rst = 1'b1;
    #1;
    chk("async rst strobes", {ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, bus_drive_en, rx_fifo_w_en, tx_fifo_r_en}, 6'b111000);
    chk("async rst burst_words", burst_words, 0);
    txq = 5;
    tick();
    rst = 1'b0;
    clear_log();
    run(20);
    chk("post-reset tie dir", bl_dir[0], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
